jstk2_spi_sequencer: RTL and testbench



---
 rtl/jstk2_pkg.sv | 23 ++
 rtl/spi_bit_engine.sv | 69 ++++++
 rtl/jstk2_spi_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_jstk2_spi_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jstk2_pkg.sv
// Shared types and constants for the PmodJSTK2 SPI sequencer.
package jstk2_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam logic [7:0] JSTK2_CMD_SET_LED = 8'h84;
  localparam int         JSTK2_BYTES       = 5;
  localparam logic [9:0] X_CENTRE          = 10'd512;
  localparam logic [9:0] Y_CENTRE          = 10'd512;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// One SPI mode-0 byte: SCLK_HALF cycles low then high per bit, MSB first,
// MOSI changes at the start of each low phase, MISO captured as SCLK rises.
module spi_bit_engine #(
  parameter int SCLK_HALF = 750
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       byte_done,
  output logic [7:0] rx_byte
);

  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  logic          active;
  logic [HW-1:0] half_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    tx_sh;
  logic [7:0]    rx_sh;
  logic          half_end;

  assign half_end  = active && (half_cnt == HW'(SCLK_HALF - 1));
  // Combinational so the sequencer can leave SHIFT on the final falling edge.
  assign byte_done = half_end && sclk && (bit_idx == 3'd7);
  assign rx_byte   = rx_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      half_cnt <= '0;
      bit_idx  <= 3'd0;
      tx_sh    <= 8'h00;
      rx_sh    <= 8'h00;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else if (!active) begin
      if (byte_start) begin
        active   <= 1'b1;
        half_cnt <= '0;
        bit_idx  <= 3'd0;
        tx_sh    <= {tx_byte[6:0], 1'b0};
        mosi     <= tx_byte[7];
        sclk     <= 1'b0;
      end
    end else if (half_end) begin
      half_cnt <= '0;
      if (!sclk) begin
        sclk  <= 1'b1;
        rx_sh <= {rx_sh[6:0], miso};
      end else begin
        sclk <= 1'b0;
        if (bit_idx == 3'd7) begin
          active <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 3'd1;
          mosi    <= tx_sh[7];
          tx_sh   <= {tx_sh[6:0], 1'b0};
        end
      end
    end else begin
      half_cnt <= half_cnt + HW'(1);
    end
  end

endmodule

// File: rtl/jstk2_spi_sequencer.sv
// PmodJSTK2 5-byte SPI transaction sequencer with auto-poll and decode.
// Optional macro JSTK2_LED_CMD_EN: send 0x84,R,G,B,0x00 instead of a plain read.
module jstk2_spi_sequencer
  import jstk2_pkg::*;
#(
  parameter int SCLK_HALF   = 750,
  parameter int T_SS_SETUP  = 1500,
  parameter int T_BYTE_GAP  = 1000,
  parameter int T_SS_HOLD   = 2500,
  parameter int POLL_PERIOD = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        start,
  input  logic        MISO,
  input  logic [23:0] led_rgb,
  output logic        SS,
  output logic        SCLK,
  output logic        MOSI,
  output logic [9:0]  x_val,
  output logic [9:0]  y_val,
  output logic [1:0]  btn,
  output logic        data_valid,
  output logic        busy,
  output state_t      fsm_state
);

  localparam int T_MAX = max3(T_SS_SETUP, T_BYTE_GAP, T_SS_HOLD);
  localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    byte_cnt_q, byte_cnt_d;
  logic          byte_start_q, byte_start_d;
  logic          ss_q, ss_d, busy_q, busy_d, dv_q, dv_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [1:0]    btn_q, btn_d;
  logic [7:0]    x_lo_q, x_lo_d, y_lo_q, y_lo_d;
  logic [1:0]    x_hi_q, x_hi_d, y_hi_q, y_hi_d;
  logic          miso_meta, miso_sync;
  logic          poll_tick, req, byte_done;
  logic [7:0]    tx_byte, rx_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= MISO;
      miso_sync <= miso_meta;
    end
  end

  generate
    if (POLL_PERIOD > 0) begin : g_poll
      localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
      logic [PW-1:0] poll_cnt;
      assign poll_tick = enable && (poll_cnt == PW'(POLL_PERIOD - 1));
      always_ff @(posedge clk) begin
        if (rst || !enable) poll_cnt <= '0;
        else if (poll_tick) poll_cnt <= '0;
        else                poll_cnt <= poll_cnt + PW'(1);
      end
    end else begin : g_no_poll
      logic unused_enable;
      assign unused_enable = enable;
      assign poll_tick     = 1'b0;
    end
  endgenerate

  assign req = start | poll_tick;

`ifdef JSTK2_LED_CMD_EN
  logic [23:0] led_q;
  // Colour is frozen at accept so a mid-transaction change cannot tear the command.
  always_ff @(posedge clk) begin
    if (rst) led_q <= 24'h0;
    else if (state_q == IDLE && req) led_q <= led_rgb;
  end

  always_comb begin
    tx_byte = 8'h00;
    case (byte_cnt_q)
      3'd0:    tx_byte = JSTK2_CMD_SET_LED;
      3'd1:    tx_byte = led_q[23:16];
      3'd2:    tx_byte = led_q[15:8];
      3'd3:    tx_byte = led_q[7:0];
      default: tx_byte = 8'h00;
    endcase
  end
`else
  logic unused_led;
  assign unused_led = ^led_rgb;
  assign tx_byte    = 8'h00;
`endif

  spi_bit_engine #(.SCLK_HALF(SCLK_HALF)) u_engine (
    .clk       (clk),
    .rst       (rst),
    .byte_start(byte_start_q),
    .tx_byte   (tx_byte),
    .miso      (miso_sync),
    .sclk      (SCLK),
    .mosi      (MOSI),
    .byte_done (byte_done),
    .rx_byte   (rx_byte)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    byte_cnt_d   = byte_cnt_q;
    byte_start_d = 1'b0;
    ss_d         = ss_q;
    busy_d       = busy_q;
    dv_d         = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    btn_d        = btn_q;
    x_lo_d       = x_lo_q;
    x_hi_d       = x_hi_q;
    y_lo_d       = y_lo_q;
    y_hi_d       = y_hi_q;
    case (state_q)
      IDLE: begin
        ss_d   = 1'b1;
        busy_d = 1'b0;
        if (req) begin
          state_d    = SETUP;
          cnt_d      = '0;
          byte_cnt_d = 3'd0;
          ss_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(T_SS_SETUP - 1)) begin
          state_d      = SHIFT;
          byte_start_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT: begin
        if (byte_done) begin
          cnt_d = '0;
          if (byte_cnt_q < 3'(JSTK2_BYTES - 1)) begin
            state_d = GAP;
            case (byte_cnt_q)
              3'd0:    x_lo_d = rx_byte;
              3'd1:    x_hi_d = rx_byte[1:0];
              3'd2:    y_lo_d = rx_byte;
              default: y_hi_d = rx_byte[1:0];
            endcase
          end else begin
            state_d = HOLD;
            ss_d    = 1'b1;
            dv_d    = 1'b1;
            x_d     = {x_hi_q, x_lo_q};
            y_d     = {y_hi_q, y_lo_q};
            btn_d   = rx_byte[1:0];
          end
        end
      end
      GAP: begin
        if (cnt_q == CW'(T_BYTE_GAP - 1)) begin
          state_d      = SHIFT;
          byte_start_d = 1'b1;
          byte_cnt_d   = byte_cnt_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == CW'(T_SS_HOLD - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      byte_cnt_q   <= 3'd0;
      byte_start_q <= 1'b0;
      ss_q         <= 1'b1;
      busy_q       <= 1'b0;
      dv_q         <= 1'b0;
      x_q          <= X_CENTRE;
      y_q          <= Y_CENTRE;
      btn_q        <= 2'b00;
      x_lo_q       <= 8'h00;
      x_hi_q       <= 2'b00;
      y_lo_q       <= 8'h00;
      y_hi_q       <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      byte_start_q <= byte_start_d;
      ss_q         <= ss_d;
      busy_q       <= busy_d;
      dv_q         <= dv_d;
      x_q          <= x_d;
      y_q          <= y_d;
      btn_q        <= btn_d;
      x_lo_q       <= x_lo_d;
      x_hi_q       <= x_hi_d;
      y_lo_q       <= y_lo_d;
      y_hi_q       <= y_hi_d;
    end
  end

  assign SS         = ss_q;
  assign busy       = busy_q;
  assign data_valid = dv_q;
  assign x_val      = x_q;
  assign y_val      = y_q;
  assign btn        = btn_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_jstk2_spi_sequencer.sv
// Directed bench for jstk2_spi_sequencer: a manual-start DUT (no auto-poll)
// and a second DUT with POLL_PERIOD=600 sharing the same pins model.
module tb_jstk2_spi_sequencer;
  import jstk2_pkg::*;

  // Busy spans 5 + 10 + 320 + 24 + 12 = 371 cycles; SS low excludes HOLD,
  // and the 5 cycles are one byte-load cycle ahead of each byte's first low phase.
  localparam int TXN_CYCLES    = 371;
  localparam int SS_LOW_CYCLES = 359;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic        miso = 1'b0;
  logic [23:0] led_rgb = 24'h12_34_56;

  logic        ss, sclk, mosi, dv, busy;
  logic [9:0]  x_val, y_val;
  logic [1:0]  btn;
  state_t      fsm_state;

  logic        p_ss, p_dv, p_busy;
  logic        unused_p_sclk, unused_p_mosi;
  logic [9:0]  unused_p_x, unused_p_y;
  logic [1:0]  unused_p_btn;
  state_t      unused_p_state;

  int checks = 0;
  int errors = 0;

  jstk2_spi_sequencer #(
    .SCLK_HALF(4), .T_SS_SETUP(10), .T_BYTE_GAP(6), .T_SS_HOLD(12), .POLL_PERIOD(0)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .MISO(miso),
    .led_rgb(led_rgb), .SS(ss), .SCLK(sclk), .MOSI(mosi), .x_val(x_val),
    .y_val(y_val), .btn(btn), .data_valid(dv), .busy(busy), .fsm_state(fsm_state)
  );

  jstk2_spi_sequencer #(
    .SCLK_HALF(4), .T_SS_SETUP(10), .T_BYTE_GAP(6), .T_SS_HOLD(12), .POLL_PERIOD(600)
  ) dut_p (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .MISO(miso),
    .led_rgb(led_rgb), .SS(p_ss), .SCLK(unused_p_sclk), .MOSI(unused_p_mosi),
    .x_val(unused_p_x), .y_val(unused_p_y), .btn(unused_p_btn), .data_valid(p_dv),
    .busy(p_busy), .fsm_state(unused_p_state)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- monitor and joystick MISO model (only writer of these counters) ----
  logic [7:0] miso_bytes [5] = '{8'hFF, 8'h03, 8'h00, 8'h02, 8'h03};
  logic [7:0] cur_byte;
  int         miso_idx = 40;
  int         cyc = 0, busy_cyc = 0, ss_low_cyc = 0, ss_falls = 0;
  int         sclk_rises = 0, dv_cnt = 0, p_falls = 0, p_dv_cnt = 0;
  int         p_fall_q[$];
  logic [39:0] mosi_sr = '0;
  logic       ss_prev = 1'b1, sclk_prev = 1'b0, p_ss_prev = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (busy === 1'b1) busy_cyc++;
    if (ss === 1'b0) ss_low_cyc++;
    if (ss_prev === 1'b1 && ss === 1'b0) ss_falls++;
    if (sclk_prev === 1'b0 && sclk === 1'b1) begin
      sclk_rises++;
      mosi_sr = {mosi_sr[38:0], mosi};
    end
    if (dv === 1'b1) dv_cnt++;
    if (p_ss_prev === 1'b1 && p_ss === 1'b0) begin
      p_falls++;
      p_fall_q.push_back(cyc);
    end
    if (p_dv === 1'b1) p_dv_cnt++;
    if (ss_prev === 1'b1 && ss === 1'b0) miso_idx = 0;
    else if (sclk_prev === 1'b1 && sclk === 1'b0) miso_idx++;
    if (miso_idx < 40) begin
      cur_byte = miso_bytes[miso_idx / 8];
      miso = cur_byte[7 - (miso_idx % 8)];
    end else begin
      miso = 1'b0;
    end
    ss_prev   = ss;
    sclk_prev = sclk;
    p_ss_prev = p_ss;
  end

  // ---- driver tasks ----
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0 || p_busy !== 1'b0) && n < bound) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, {31'b0, (busy !== 1'b0 || p_busy !== 1'b0)}, 32'd0);
  endtask

  int s_busy, s_sslow, s_falls, s_rises, s_dv, s_pfalls, s_pdv, s_pq, enable_cyc, n;
  logic [39:0] exp_mosi;

  task automatic snap();
    s_busy   = busy_cyc;
    s_sslow  = ss_low_cyc;
    s_falls  = ss_falls;
    s_rises  = sclk_rises;
    s_dv     = dv_cnt;
    s_pfalls = p_falls;
    s_pdv    = p_dv_cnt;
    s_pq     = p_fall_q.size();
  endtask

  initial begin
`ifdef JSTK2_LED_CMD_EN
    exp_mosi = {8'h84, 8'h12, 8'h34, 8'h56, 8'h00};
`else
    exp_mosi = 40'h0;
`endif
    // Reset state
    repeat (5) tick();
    rst = 1'b0;
    tick();
    check("rst_ss", {31'b0, ss}, 32'd1);
    check("rst_sclk", {31'b0, sclk}, 32'd0);
    check("rst_mosi", {31'b0, mosi}, 32'd0);
    check("rst_x", {22'b0, x_val}, 32'd512);
    check("rst_y", {22'b0, y_val}, 32'd512);
    check("rst_btn", {30'b0, btn}, 32'd0);
    check("rst_dv", {31'b0, dv}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));

    // Idle with no request
    snap();
    repeat (50) tick();
    check("idle_dv", dv_cnt - s_dv, 32'd0);
    check("idle_ss_falls", ss_falls - s_falls, 32'd0);
    check("idle_sclk", sclk_rises - s_rises, 32'd0);

    // Single manual transaction
    snap();
    pulse_start();
    wait_idle(1000, "txn1");
    check("txn1_busy_len", busy_cyc - s_busy, TXN_CYCLES);
    check("txn1_ss_low", ss_low_cyc - s_sslow, SS_LOW_CYCLES);
    check("txn1_sclk_rises", sclk_rises - s_rises, 32'd40);
    check("txn1_dv", dv_cnt - s_dv, 32'd1);
    check("txn1_x", {22'b0, x_val}, 32'd1023);
    check("txn1_y", {22'b0, y_val}, 32'd512);
    check("txn1_btn", {30'b0, btn}, 32'd3);
    check("txn1_ss_idle", {31'b0, ss}, 32'd1);
    for (int i = 0; i < 5; i++)
      check("txn1_mosi_byte", {24'b0, mosi_sr[39 - 8*i -: 8]}, {24'b0, exp_mosi[39 - 8*i -: 8]});

    // Start while busy is dropped
    snap();
    pulse_start();
    repeat (100) tick();
    check("busy_mid", {31'b0, busy}, 32'd1);
    pulse_start();
    wait_idle(1000, "txn2");
    repeat (20) tick();
    check("busy_drop_falls", ss_falls - s_falls, 32'd1);
    check("busy_drop_dv", dv_cnt - s_dv, 32'd1);
    check("busy_drop_len", busy_cyc - s_busy, TXN_CYCLES);

    // Reset at bit 20 aborts
    snap();
    pulse_start();
    n = 0;
    while (sclk_rises - s_rises < 20 && n < 1000) begin
      tick();
      n++;
    end
    check("abort_wait_timeout", {31'b0, (sclk_rises - s_rises < 20)}, 32'd0);
    rst = 1'b1;
    tick();
    check("abort_ss", {31'b0, ss}, 32'd1);
    check("abort_sclk", {31'b0, sclk}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_mosi", {31'b0, mosi}, 32'd0);
    check("abort_x", {22'b0, x_val}, 32'd512);
    check("abort_y", {22'b0, y_val}, 32'd512);
    check("abort_btn", {30'b0, btn}, 32'd0);
    check("abort_state", 32'(fsm_state), 32'(IDLE));
    rst = 1'b0;
    repeat (500) tick();
    check("abort_dv", dv_cnt - s_dv, 32'd0);
    check("abort_falls", ss_falls - s_falls, 32'd1);
    check("abort_x_after", {22'b0, x_val}, 32'd512);

    // Auto-poll at 600 cycles; start coincides with first tick, then start while busy
    snap();
    enable = 1'b1;
    enable_cyc = cyc;
    repeat (599) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("poll_p_busy", {31'b0, p_busy}, 32'd1);
    check("poll_main_busy", {31'b0, busy}, 32'd1);
    repeat (100) tick();
    pulse_start();
    repeat (3000 - 701) tick();
    enable = 1'b0;
    wait_idle(1000, "poll");
    check("poll_count", p_falls - s_pfalls, 32'd5);
    check("poll_dv", p_dv_cnt - s_pdv, 32'd5);
    check("poll_main_falls", ss_falls - s_falls, 32'd1);
    check("poll_main_dv", dv_cnt - s_dv, 32'd1);
    if (p_fall_q.size() >= s_pq + 5) begin
      check("poll_first", p_fall_q[s_pq] - enable_cyc, 32'd600);
      for (int i = 1; i < 5; i++)
        check("poll_spacing", p_fall_q[s_pq + i] - p_fall_q[s_pq + i - 1], 32'd600);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
